// File: rtl/nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_responder
// Purpose  : Controller-side emulation of the NES pad's 4021 shift register.
//            Answers latch/pulse strobes from the console-side initiator by
//            shifting an 8-bit button word out on o_nes_data, A first.
// Revision : 1.0  initial release
//
// Ports
//   clk           in   system clock (50 MHz)
//   reset         in   synchronous, active-low reset
//   i_nes_latch   in   latch strobe, asynchronous, active-high
//   i_nes_pulse   in   shift clock, asynchronous, rising edge advances a bit
//   i_buttons     in   [7:0] 1 = pressed; 7 A, 6 B, 5 Sel, 4 Start,
//                      3 Up, 2 Down, 1 Left, 0 Right
//   o_nes_data    out  serial data, active-low, idles high
//   o_frame_done  out  one-cycle pulse when the 8th shift pulse is accepted
//   o_bit_count   out  [3:0] pulses accepted since last latch, saturates at 8
//   i_turbo_a     in   auto-fire enable for A  (NES_TURBO_EN only)
//   i_turbo_b     in   auto-fire enable for B  (NES_TURBO_EN only)
//
// Build option
//   NES_TURBO_EN  adds the turbo inputs, the TURBO_FRAMES parameter and a
//                 frame counter that auto-fires A/B. Undefined by default.
// ============================================================================
module nes_pad_responder #(
  parameter int SYNC_STAGES  = 2
`ifdef NES_TURBO_EN
  ,
  parameter int TURBO_FRAMES = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_nes_latch,
  input  logic       i_nes_pulse,
  input  logic [7:0] i_buttons,
  output logic       o_nes_data,
  output logic       o_frame_done,
  output logic [3:0] o_bit_count
`ifdef NES_TURBO_EN
  ,
  input  logic       i_turbo_a,
  input  logic       i_turbo_b
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_pulse_sync;
  logic                   r_latch_q;     // retimed so latch lines up with edge
  logic                   r_pulse_d;
  logic                   r_pulse_edge;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_latch_sync <= '0;
      r_pulse_sync <= '0;
      r_latch_q    <= 1'b0;
      r_pulse_d    <= 1'b0;
      r_pulse_edge <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_nes_latch};
      r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], i_nes_pulse};
      // Both internal strobes arrive SYNC_STAGES+1 cycles after the pins, so
      // a latch and a pulse hitting the pins together are seen together.
      r_latch_q    <= r_latch_sync[SYNC_STAGES-1];
      r_pulse_d    <= r_pulse_sync[SYNC_STAGES-1];
      r_pulse_edge <= r_pulse_sync[SYNC_STAGES-1] & ~r_pulse_d;
    end
  end

  // --------------------------------------------------------------------------
  // Effective button word
  // --------------------------------------------------------------------------
  logic [7:0] w_buttons_eff;
  logic       w_done_nxt;

`ifdef NES_TURBO_EN
  localparam int c_TW = (2 * TURBO_FRAMES > 2) ? $clog2(2 * TURBO_FRAMES) : 1;
  localparam logic [c_TW-1:0] c_HALF = c_TW'(TURBO_FRAMES);
  localparam logic [c_TW-1:0] c_LAST = c_TW'(2 * TURBO_FRAMES - 1);

  logic [c_TW-1:0] r_turbo_cnt;
  logic            w_turbo_on;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_turbo_cnt <= '0;
    end else if (!i_turbo_a && !i_turbo_b) begin
      r_turbo_cnt <= '0;
    end else if (w_done_nxt) begin
      r_turbo_cnt <= (r_turbo_cnt == c_LAST) ? '0 : r_turbo_cnt + c_TW'(1);
    end
  end

  // First half of the turbo period reads as pressed.
  assign w_turbo_on    = (r_turbo_cnt < c_HALF);
  assign w_buttons_eff = {i_buttons[7] | (i_turbo_a & w_turbo_on),
                          i_buttons[6] | (i_turbo_b & w_turbo_on),
                          i_buttons[5:0]};
`else
  assign w_buttons_eff = i_buttons;
`endif

  // --------------------------------------------------------------------------
  // Frame state machine and shift datapath
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shreg;
  logic [7:0] w_shreg_nxt;
  logic [3:0] r_bit_count;
  logic [3:0] w_count_nxt;
  logic       r_nes_data;
  logic       w_data_nxt;
  logic       r_frame_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shreg      <= 8'h00;
      r_bit_count  <= 4'd0;
      r_nes_data   <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_count  <= w_count_nxt;
      r_nes_data   <= w_data_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_count_nxt = r_bit_count;
    w_data_nxt  = r_nes_data;
    w_done_nxt  = 1'b0;

    if (r_latch_q) begin
      // Parallel mode: keep reloading, any coincident pulse edge is dropped.
      w_state_nxt = S_LOAD;
      w_shreg_nxt = w_buttons_eff;
      w_count_nxt = 4'd0;
      w_data_nxt  = ~w_buttons_eff[7];
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_LOAD: begin
          w_state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          if (r_pulse_edge) begin
            w_shreg_nxt = {r_shreg[6:0], 1'b0};
            w_count_nxt = r_bit_count + 4'd1;
            // New MSB after the shift; zero fill makes the 8th bit idle high.
            w_data_nxt  = ~r_shreg[6];
            if (r_bit_count == 4'd7) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign o_nes_data   = r_nes_data;
  assign o_frame_done = r_frame_done;
  assign o_bit_count  = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_pad_responder
// Purpose  : Self-checking bench for nes_pad_responder: table of frame
//            vectors, hand-written corner sequences and randomized frames
//            checked against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_nes_pad_responder;

  localparam int SYNC = 2;
  localparam int WAIT = SYNC + 4;   // cycles for a pin change to settle inside

  logic       clk = 1'b0;
  logic       reset;
  logic       latch;
  logic       pulse;
  logic [7:0] buttons;
  logic       data;
  logic       done;
  logic [3:0] cnt;
`ifdef NES_TURBO_EN
  logic       turbo_a;
  logic       turbo_b;
`endif

  always #10 clk = ~clk;

`ifdef NES_TURBO_EN
  nes_pad_responder #(.SYNC_STAGES(SYNC), .TURBO_FRAMES(2)) dut (
`else
  nes_pad_responder #(.SYNC_STAGES(SYNC)) dut (
`endif
    .clk          (clk),
    .reset        (reset),
    .i_nes_latch  (latch),
    .i_nes_pulse  (pulse),
    .i_buttons    (buttons),
    .o_nes_data   (data),
    .o_frame_done (done),
    .o_bit_count  (cnt)
`ifdef NES_TURBO_EN
    ,
    .i_turbo_a    (turbo_a),
    .i_turbo_b    (turbo_b)
`endif
  );

  int errors = 0;
  int checks = 0;

  // frame_done monitor: total pulses seen, and any pulse longer than a cycle
  int   done_cnt  = 0;
  int   done_wide = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev === 1'b1) done_wide++;
    end
    done_prev = done;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic latch_frame(input logic [7:0] w);
    buttons = w;
    latch   = 1'b1;
    cyc(WAIT);
    latch   = 1'b0;
    cyc(WAIT);
  endtask

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      pulse = 1'b1;
      cyc(WAIT);
      pulse = 1'b0;
      cyc(WAIT);
    end
  endtask

  // Reference model: what the pad shows after k pulses of snapshot word w
  function automatic logic model_data(input logic [7:0] w, input int k);
    return (k < 8) ? ~w[7-k] : 1'b1;
  endfunction
  function automatic int model_cnt(input int k);
    return (k > 8) ? 8 : k;
  endfunction

  typedef struct {
    logic [7:0] btn;
    int         np;
    logic       exp_data;
    logic [3:0] exp_cnt;
    int         exp_done;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int         d0;
    logic [7:0] w;
    int         k;
    logic [7:0] seq;

    tbl[0] = '{8'h91, 0, 1'b0, 4'd0, 0};
    tbl[1] = '{8'h91, 3, 1'b0, 4'd3, 0};
    tbl[2] = '{8'h91, 8, 1'b1, 4'd8, 1};
    tbl[3] = '{8'h91, 9, 1'b1, 4'd8, 1};
    tbl[4] = '{8'h00, 0, 1'b1, 4'd0, 0};
    tbl[5] = '{8'h40, 1, 1'b0, 4'd1, 0};
    tbl[6] = '{8'h01, 7, 1'b0, 4'd7, 0};
    tbl[7] = '{8'hFF, 5, 1'b0, 4'd5, 0};
    tbl[8] = '{8'h7F, 0, 1'b1, 4'd0, 0};

    reset   = 1'b0;
    latch   = 1'b0;
    pulse   = 1'b0;
    buttons = 8'h00;
`ifdef NES_TURBO_EN
    turbo_a = 1'b0;
    turbo_b = 1'b0;
`endif

    // ---- reset with strobes toggling ----
    @(negedge clk); latch = 1'b1; pulse = 1'b1;
    @(negedge clk); latch = 1'b0; pulse = 1'b0;
    check("reset_data", 32'(data), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cnt",  32'(cnt),  32'd0);
    reset = 1'b1;
    cyc(WAIT);

    // ---- pulse from IDLE is ignored ----
    pulse_n(2);
    check("idle_cnt",  32'(cnt),      32'd0);
    check("idle_data", 32'(data),     32'd1);
    check("idle_done", 32'(done_cnt), 32'd0);

    // ---- table vectors ----
    for (int i = 0; i < 9; i++) begin
      d0 = done_cnt;
      latch_frame(tbl[i].btn);
      pulse_n(tbl[i].np);
      check($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_cnt", i),  32'(cnt),  32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_done", i), 32'(done_cnt - d0), 32'(tbl[i].exp_done));
    end

    // ---- normal frame bit by bit ----
    seq = 8'b0110_1110;   // expected nes_data for 8'b1001_0001, first bit left
    d0  = done_cnt;
    latch_frame(8'b1001_0001);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frame_bit%0d", i), 32'(data), 32'(seq[7-i]));
      pulse_n(1);
    end
    check("frame_fill",  32'(data),           32'd1);
    check("frame_cnt",   32'(cnt),            32'd8);
    check("frame_done",  32'(done_cnt - d0),  32'd1);
    pulse_n(1);
    check("frame_9th_data", 32'(data),          32'd1);
    check("frame_9th_done", 32'(done_cnt - d0), 32'd1);
    check("frame_9th_cnt",  32'(cnt),           32'd8);

    // ---- snapshot: buttons change after latch falls ----
    latch_frame(8'h80);
    buttons = 8'h01;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("snap_bit%0d", i), 32'(data), (i == 0) ? 32'd0 : 32'd1);
      pulse_n(1);
    end

    // ---- abort mid-frame ----
    latch_frame(8'h91);
    pulse_n(3);
    d0 = done_cnt;
    latch_frame(8'h40);
    check("abort_cnt",  32'(cnt),  32'd0);
    check("abort_data", 32'(data), 32'd1);
    pulse_n(1);
    check("abort_p1_data", 32'(data), 32'd0);
    check("abort_p1_cnt",  32'(cnt),  32'd1);
    check("abort_done",    32'(done_cnt - d0), 32'd0);

    // ---- pulses while latch held ----
    buttons = 8'h80;
    latch   = 1'b1;
    cyc(WAIT);
    pulse_n(2);
    check("latchpulse_cnt",  32'(cnt),  32'd0);
    check("latchpulse_data", 32'(data), 32'd0);
    buttons = 8'h00;
    cyc(WAIT);
    check("latch_track_data", 32'(data), 32'd1);
    latch = 1'b0;
    cyc(WAIT);

    // ---- latch and pulse rising together ----
    latch_frame(8'hC0);
    pulse_n(2);
    buttons = 8'h80;
    latch   = 1'b1;
    pulse   = 1'b1;
    cyc(WAIT);
    pulse   = 1'b0;
    cyc(WAIT);
    latch   = 1'b0;
    cyc(WAIT);
    check("same_cyc_cnt",  32'(cnt),  32'd0);
    check("same_cyc_data", 32'(data), 32'd0);
    pulse_n(1);
    check("same_cyc_p1_cnt",  32'(cnt),  32'd1);
    check("same_cyc_p1_data", 32'(data), 32'd1);

    // ---- reset mid-frame ----
    latch_frame(8'h91);
    pulse_n(3);
    d0 = done_cnt;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(WAIT);
    check("rst_mid_cnt",  32'(cnt),  32'd0);
    check("rst_mid_data", 32'(data), 32'd1);
    pulse_n(8);
    check("rst_mid_idle_cnt", 32'(cnt),          32'd0);
    check("rst_mid_done",     32'(done_cnt - d0), 32'd0);

    // ---- randomized frames against the reference model ----
    for (int f = 0; f < 40; f++) begin
      w  = 8'($urandom);
      k  = $urandom_range(0, 10);
      d0 = done_cnt;
      latch_frame(w);
      buttons = 8'($urandom);   // must not disturb the snapshot
      pulse_n(k);
      check($sformatf("rnd%0d_data", f), 32'(data), 32'(model_data(w, k)));
      check($sformatf("rnd%0d_cnt", f),  32'(cnt),  32'(model_cnt(k)));
      check($sformatf("rnd%0d_done", f), 32'(done_cnt - d0), (k >= 8) ? 32'd1 : 32'd0);
    end

`ifdef NES_TURBO_EN
    // ---- turbo A, TURBO_FRAMES=2: pressed 1-2, released 3-4, pressed 5-6 ----
    turbo_a = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      latch_frame(8'h00);
      check($sformatf("turbo_f%0d", f), 32'(data),
            (((f - 1) / 2) % 2 == 0) ? 32'd0 : 32'd1);
      pulse_n(8);
    end
    turbo_a = 1'b0;
`endif

    check("done_single_cycle", 32'(done_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Controller-side end of the NES serial pad link: emulates the pad's 4021 parallel-in/serial-out register.
- Answers latch/pulse strobes from the console-side initiator by shifting out an 8-bit button word on nes_data.
- Used as a bench/emulation stand-in for a physical pad and for loopback bring-up of the input path.
- Button word comes from a parallel bus, typically a test sequencer or board switches.

Parameters:
- SYNC_STAGES, 2: flops in each input synchronizer for nes_latch and nes_pulse; legal range 2..4.
- TURBO_FRAMES, 4: frames per turbo half-period; used only when NES_TURBO_EN is defined; must be at least 1.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low reset
- nes_latch  in  1  latch strobe from the initiator, asynchronous, active-high
- nes_pulse  in  1  shift clock from the initiator, asynchronous; rising edge advances one bit
- buttons  in  8  1 = pressed; bit7 A, bit6 B, bit5 Select, bit4 Start, bit3 Up, bit2 Down, bit1 Left, bit0 Right
- nes_data  out  1  serial data, active-low (0 = pressed), idle high
- frame_done  out  1  one-cycle pulse when the 8th shift pulse is accepted
- bit_count  out  4  shift pulses accepted since the last latch, 0..8, saturating
- turbo_a  in  1  NES_TURBO_EN only; auto-fire enable for A
- turbo_b  in  1  NES_TURBO_EN only; auto-fire enable for B

Behaviour:
- Reset (reset=0 at a clk edge) clears all state:
  - nes_data=1, frame_done=0, bit_count=0, shift register=0, synchronizers=0, state=IDLE, turbo counters=0.
- Reset mid-frame abandons the frame; no frame_done is produced.
- Inputs: nes_latch and nes_pulse each pass through SYNC_STAGES flops, then a registered rising-edge detector on nes_pulse.
  - Pin-to-internal latency is SYNC_STAGES+1 cycles.
- States:
  - IDLE: waiting for a latch.
  - LOAD: synced latch high.
  - SHIFT: latch low, bit_count < 8.
  - DONE: bit_count = 8.
- Transitions:
  - Synced latch high in any state goes to LOAD. Latch has priority over everything except reset.
  - LOAD to SHIFT when synced latch falls.
  - SHIFT to DONE on the 8th accepted pulse.
  - DONE stays until the next latch.
- LOAD:
  - Shift register loads the effective buttons every cycle; bit_count=0.
  - nes_data = ~buttons_eff[7], registered, one cycle after load.
  - Pulse edges are ignored, matching parallel-mode behaviour.
- Snapshot: the value loaded on the last LOAD cycle is the frame word. Changes on buttons after the latch falls have no effect until the next latch.
- SHIFT:
  - Each accepted pulse edge shifts the register left, filling 0 (not pressed), and increments bit_count.
  - nes_data updates to ~shreg[7] on the cycle after the edge.
  - Resulting order on nes_data: A, B, Select, Start, Up, Down, Left, Right. The first bit is visible before any pulse.
- 8th accepted pulse: bit_count=8, frame_done=1 for exactly one cycle, nes_data=1 (fill).
- DONE: further pulses are ignored. bit_count holds 8, nes_data holds 1, and no further frame_done is generated.
- Latch in SHIFT before 8 pulses: frame aborted, bit_count=0, no frame_done, reload as in LOAD.
- Latch and pulse edges in the same cycle: latch wins and the pulse is discarded.
- A pulse edge from IDLE (no latch since reset) is ignored; bit_count stays 0 and nes_data stays 1.

Optional Feature:
- NES_TURBO_EN defined:
  - turbo_a and turbo_b ports exist.
  - A frame counter increments on each frame_done and wraps at 2*TURBO_FRAMES.
  - While turbo_a=1, effective A = buttons[7] OR (counter < TURBO_FRAMES); likewise for B with turbo_b.
  - The counter resets to 0 when both turbo inputs are 0.
- NES_TURBO_EN undefined: no turbo ports, no counter logic; effective buttons = buttons.

Test Plan:
- Reset: hold reset=0 two cycles with strobes toggling -> nes_data=1, frame_done=0, bit_count=0.
- Normal frame: buttons=8'b1001_0001, latch high then low, then 8 pulses -> nes_data reads 0,1,1,0,1,1,1,0 (first value before any pulse); frame_done single cycle on the 8th pulse, bit_count=8; a 9th pulse leaves nes_data=1 with no new frame_done.
- Snapshot: buttons=8'h80, latch, then change to 8'h01 after latch falls -> serial word still reads A pressed only (0 then 1 x7).
- Abort: 3 pulses, then latch reasserted with buttons=8'h40 -> bit_count=0, nes_data=1 (A released), then 0 after 1 pulse; no frame_done for the aborted frame.
- Pulse during latch, and same-cycle latch+pulse -> bit_count stays 0, nes_data tracks ~buttons[7].
- NES_TURBO_EN, TURBO_FRAMES=2, turbo_a=1, buttons=0 -> A reads pressed in frames 1-2, released in 3-4, pressed in 5-6.
